branch_outcome_tracker: RTL
===========================

Name: branch_outcome_tracker

Overview:
- In-order tracker for branch predictions that are in flight. It sits between fetch/execute and the two-bit-counter predictor table, and drives that table's update side.
- Fetch pushes each prediction it consumes: table index plus predicted direction. Execute resolves branches in program order.
- On resolution the tracker issues the table update (set, set_index, feedback), detects mispredictions and squashes younger entries.
- It also forwards entry-replacement events as table reset requests and keeps stale entries from training a recycled slot.

Parameters:
DEPTH, 8, number of in-flight entries (power of two, 2..64)
IDX_W, 8, width of predictor table index

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low; clears all state
pred_valid  input  1  fetch pushes a prediction this cycle
pred_index  input  IDX_W  table index used for the prediction
pred_taken  input  1  predicted direction (1 = taken)
pred_ready  output  1  tracker can accept a push (count < DEPTH)
res_valid  input  1  oldest in-flight branch resolves this cycle
res_taken  input  1  actual outcome of resolving branch
evict_valid  input  1  table slot evict_index is being reassigned to a new PC
evict_index  input  IDX_W  slot being reassigned
tbl_set  output  1  update strobe to predictor table
tbl_set_index  output  IDX_W  index to update
tbl_feedback  output  1  outcome to train with
tbl_reset  output  1  reset strobe to predictor table
tbl_reset_index  output  IDX_W  index to reset to weakly-not-taken
mispredict  output  1  one-cycle pulse: resolved outcome differed from prediction
count  output  $clog2(DEPTH)+1  number of valid entries
overflow_err  output  1  sticky: push attempted while full
underflow_err  output  1  sticky: resolve attempted while empty

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, count 0, pred_ready 1.
  - Head/tail pointers 0, all entry valid/stale bits 0.
- Storage: circular buffer of DEPTH entries {index, pred, stale}. Head = oldest entry, tail = next free slot. Pointers wrap modulo DEPTH.
- pred_ready is a registered function of count only; it does not depend on same-cycle pops.
- Push: pred_valid && pred_ready writes the entry at tail with stale=0, then tail+1.
  - pred_valid while full: push dropped, overflow_err set, no other state change.
- Resolve: res_valid && count>0 pops the head entry.
  - Next cycle: tbl_set=1, tbl_set_index=head.index, tbl_feedback=res_taken. Update latency is exactly 1 cycle.
  - If head.stale=1: tbl_set stays 0 (no training of a reassigned slot). Misprediction is still evaluated.
  - If res_taken != head.pred: mispredict=1 next cycle. All entries younger than head are discarded (count becomes 0, tail=head+1). A push in the same cycle is also discarded.
  - res_valid while empty: ignored, underflow_err set.
- Simultaneous push and correct-prediction pop: both take effect, count unchanged. This is allowed even when full only if pred_ready was 1, i.e. never at count=DEPTH.
- Evict:
  - evict_valid gives tbl_reset=1 and tbl_reset_index=evict_index the next cycle.
  - Every valid entry whose index == evict_index gets stale=1 in the same edge, including an entry pushed that same cycle with a matching index.
  - If the resolve in the same cycle targets the same index, the set is suppressed: reset wins, and the table never sees set and reset on one index in one cycle.
- All table-side and mispredict outputs are single-cycle pulses from registers; no combinational path from inputs to outputs.
- Sticky error flags clear only on reset.

Test Plan:
- Reset, push {0x12,T},{0x34,N}, resolve T then N -> tbl_set pulses idx 0x12 fb 1, then idx 0x34 fb 0, each 1 cycle after res_valid; mispredict stays 0; count 2→1→0.
- Push 3 entries {0x05,T},{0x06,T},{0x07,N}, resolve N -> tbl_set idx 0x05 fb 0, mispredict=1, count 0; later resolve with empty -> underflow_err=1, no tbl_set.
- Push DEPTH=8 entries -> pred_ready=0; 9th push -> dropped, overflow_err=1. Resolve all 8 -> indices emerge in push order across the pointer wrap.
- Push {0x40,N}, evict_valid idx 0x40, then resolve N -> tbl_reset idx 0x40 pulse; at resolve tbl_set=0, mispredict=0.
- Same cycle: resolve head {0x22,T} with T and evict 0x22 -> next cycle tbl_reset idx 0x22=1, tbl_set=0.
- Assert reset mid-stream with 5 entries held -> count=0, all strobes 0 immediately; first resolve after release -> underflow_err=1.

Source files
------------

// File: rtl/branch_outcome_tracker.sv
// In-order tracker of in-flight branch predictions; drives the predictor table's update/reset side.
// All outputs are registered (1-cycle latency from push/resolve/evict); pred_ready deasserts while full.
module branch_outcome_tracker #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pred_valid,
  input  logic [IDX_W-1:0]         pred_index,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic                     evict_valid,
  input  logic [IDX_W-1:0]         evict_index,
  output logic                     tbl_set,
  output logic [IDX_W-1:0]         tbl_set_index,
  output logic                     tbl_feedback,
  output logic                     tbl_reset,
  output logic [IDX_W-1:0]         tbl_reset_index,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IDX_W-1:0] idx_q [DEPTH];
  logic [IDX_W-1:0] idx_d [DEPTH];
  logic [DEPTH-1:0] pred_q, pred_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] stale_q, stale_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pred_ready_q, pred_ready_d;

  logic             tbl_set_q, tbl_set_d;
  logic [IDX_W-1:0] tbl_set_index_q, tbl_set_index_d;
  logic             tbl_feedback_q, tbl_feedback_d;
  logic             tbl_reset_q, tbl_reset_d;
  logic [IDX_W-1:0] tbl_reset_index_q, tbl_reset_index_d;
  logic             mispredict_q, mispredict_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [IDX_W-1:0] head_idx;
  logic             head_pred;
  logic             head_stale;
  logic             push;
  logic             pop;
  logic             miss;
  logic             evict_hits_head;

  always_comb begin
    head_idx        = idx_q[head_q];
    head_pred       = pred_q[head_q];
    head_stale      = stale_q[head_q];
    push            = pred_valid && pred_ready_q;
    pop             = res_valid && (count_q != '0);
    miss            = pop && (res_taken != head_pred);
    evict_hits_head = evict_valid && (evict_index == head_idx);
  end

  always_comb begin
    idx_d   = idx_q;
    pred_d  = pred_q;
    valid_d = valid_q;
    stale_d = stale_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    // A reassigned slot must never be trained by predictions made for the old PC.
    if (evict_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (idx_q[i] == evict_index)) begin
          stale_d[i] = 1'b1;
        end
      end
    end

    if (push) begin
      idx_d[tail_q]   = pred_index;
      pred_d[tail_q]  = pred_taken;
      valid_d[tail_q] = 1'b1;
      stale_d[tail_q] = evict_valid && (pred_index == evict_index);
      tail_d          = tail_q + PW'(1);
    end

    if (pop) begin
      valid_d[head_q] = 1'b0;
      stale_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end

    // Everything younger than a mispredicted branch is wrong-path, including this cycle's push.
    if (miss) begin
      valid_d = '0;
      stale_d = '0;
      tail_d  = head_q + PW'(1);
      count_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
    end

    pred_ready_d = (count_d != CW'(DEPTH));
  end

  always_comb begin
    tbl_set_d         = pop && !head_stale && !evict_hits_head;
    tbl_set_index_d   = pop ? head_idx : '0;
    tbl_feedback_d    = pop && res_taken;
    tbl_reset_d       = evict_valid;
    tbl_reset_index_d = evict_valid ? evict_index : '0;
    mispredict_d      = miss;
    overflow_d        = overflow_q || (pred_valid && !pred_ready_q);
    underflow_d       = underflow_q || (res_valid && (count_q == '0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx_q[i] <= '0;
      end
      pred_q       <= '0;
      valid_q      <= '0;
      stale_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      pred_ready_q <= 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        idx_q[i] <= idx_d[i];
      end
      pred_q       <= pred_d;
      valid_q      <= valid_d;
      stale_q      <= stale_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      pred_ready_q <= pred_ready_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tbl_set_q         <= 1'b0;
      tbl_set_index_q   <= '0;
      tbl_feedback_q    <= 1'b0;
      tbl_reset_q       <= 1'b0;
      tbl_reset_index_q <= '0;
      mispredict_q      <= 1'b0;
      overflow_q        <= 1'b0;
      underflow_q       <= 1'b0;
    end else begin
      tbl_set_q         <= tbl_set_d;
      tbl_set_index_q   <= tbl_set_index_d;
      tbl_feedback_q    <= tbl_feedback_d;
      tbl_reset_q       <= tbl_reset_d;
      tbl_reset_index_q <= tbl_reset_index_d;
      mispredict_q      <= mispredict_d;
      overflow_q        <= overflow_d;
      underflow_q       <= underflow_d;
    end
  end

  assign pred_ready      = pred_ready_q;
  assign count           = count_q;
  assign tbl_set         = tbl_set_q;
  assign tbl_set_index   = tbl_set_index_q;
  assign tbl_feedback    = tbl_feedback_q;
  assign tbl_reset       = tbl_reset_q;
  assign tbl_reset_index = tbl_reset_index_q;
  assign mispredict      = mispredict_q;
  assign overflow_err    = overflow_q;
  assign underflow_err   = underflow_q;

endmodule
